uifdma_axi_wr: RTL and testbench
================================

// Module: uifdma_axi_wr
// PURPOSE
// - FDMA write-request responder: accepts fdma_wareq/waddr/wsize from a frame buffer controller (uidbuf side).
// - Pulls beats from the controller's FWFT FIFO and issues AXI4 INCR write bursts to DDR.
// - Sits between uidbuf's fdma_w* port and the DDR AXI4 slave; drives the fdma_wbusy/fdma_wvalid seen by uidbuf.
// PARAMETERS
// AXI_DATA_WIDTH      128  beat width in bits; power of 2, >=32
// AXI_ADDR_WIDTH      32   byte address width
// M_AXI_MAX_BURST_LEN 64   max beats per AXI burst, 1..256
// PORTS
// M_AXI_ACLK      in   1                 the single clock
// M_AXI_ARESETN   in   1                 asynchronous active-low reset
// fdma_waddr      in   AXI_ADDR_WIDTH    start byte address, beat-aligned, sampled with fdma_wareq
// fdma_wareq      in   1                 request pulse
// fdma_wsize      in   16                transfer length in beats
// fdma_wbusy      out  1                 transfer in progress
// fdma_wdata      in   AXI_DATA_WIDTH    FWFT data from controller
// fdma_wvalid     out  1                 beat consumed this cycle (controller FIFO read strobe)
// fdma_wready     in   1                 controller has a beat available
// M_AXI_AWADDR    out  AXI_ADDR_WIDTH    burst address
// M_AXI_AWLEN     out  8                 beats-1
// M_AXI_AWVALID   out  1                 AW valid
// M_AXI_AWREADY   in   1                 AW ready
// M_AXI_WDATA     out  AXI_DATA_WIDTH    = fdma_wdata (combinational)
// M_AXI_WSTRB     out  AXI_DATA_WIDTH/8  constant all ones
// M_AXI_WLAST     out  1                 last beat of burst
// M_AXI_WVALID    out  1                 W valid
// M_AXI_WREADY    in   1                 W ready
// M_AXI_BRESP     in   2                 write response
// M_AXI_BVALID    in   1                 B valid
// M_AXI_BREADY    out  1                 B ready
// fdma_werr       out  1                 sticky: non-OKAY BRESP seen in current transfer
// BEHAVIOUR
// - Reset: state IDLE; fdma_wbusy, fdma_wvalid, AWVALID, WVALID, WLAST, BREADY, fdma_werr = 0; AWADDR/AWLEN = 0.
// - FSM IDLE->AW->W->B->(AW | IDLE). One burst outstanding; AWSIZE=log2(bytes/beat), AWBURST=INCR tied off by integrator.
// - IDLE: fdma_wareq with fdma_wsize!=0 latches addr/size, clears fdma_werr; cycle N+1: fdma_wbusy=1, AWVALID=1.
//   fdma_wsize==0 ignored (busy stays 0). fdma_wareq while busy ignored.
// - Burst len L = min(remaining, M_AXI_MAX_BURST_LEN, beats to next 4 KB boundary); AWLEN=L-1, held stable until AWREADY.
// - W: M_AXI_WVALID = fdma_wready in W state; fdma_wvalid = M_AXI_WVALID & M_AXI_WREADY (same-cycle FIFO pop).
//   Beat counter counts handshakes; WLAST=1 on beat L-1; WLAST&handshake -> B. No W before AW accepted.
// - B: BREADY=1; on BVALID: BRESP!=OKAY sets fdma_werr; remaining-=L, addr+=L*(AXI_DATA_WIDTH/8);
//   remaining>0 -> AW (next AWVALID the following cycle), else IDLE, fdma_wbusy=0 the following cycle.
// - Stalls: fdma_wready=0 or WREADY=0 holds beat count and data; no timeout.
// - Address wraps modulo 2^AXI_ADDR_WIDTH; remaining is 16-bit, max 65535 beats.
// - Reset mid-transfer: immediate return to reset values; transfer abandoned, not resumed.
// STRUCTURE
// - Shared package: FSM state encoding, AXI_BURST_INCR/AXI_RESP_OKAY constants, 4 KB boundary constant.
// - Burst-length calc (min of three + 4 KB distance) as sub-module uifdma_burst_calc; rest flat.
// TESTING
// - waddr=0x0, wsize=1 -> one burst AWLEN=0, WLAST on beat 0, busy high N+1 until cycle after BVALID.
// - 128-bit, waddr=0x0, wsize=256, MAX=64 -> 4 bursts AWADDR 0x0/0x400/0x800/0xC00, AWLEN=63 each.
// - waddr=0xF80, wsize=16 (16 B beats) -> bursts AWADDR 0xF80 AWLEN=7, then 0x1000 AWLEN=7.
// - fdma_wready toggling 1/0 and random WREADY -> exact beat count, data order preserved, fdma_wvalid only on handshake.
// - BRESP=SLVERR on 2nd of 3 bursts -> fdma_werr=1 to end; next wareq clears it; wareq while busy ignored.
// - ARESETN low mid-W -> all outputs 0 next edge; new wareq after release completes normally.

Source files
------------

// File: rtl/uifdma_axi_wr_pkg.sv
`default_nettype none
//============================================================================
// Module      : uifdma_axi_wr_pkg
// Description : Shared definitions for the FDMA AXI4 write engine.
//               - FSM state encoding
//               - AXI burst-type and response codes
//               - 4 KB address-boundary constants
// Revision    : 1.0 - initial release
//============================================================================
package uifdma_axi_wr_pkg;

  // Write-engine FSM.
  // IDLE -> AW -> W -> B -> (AW | IDLE)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  // AXI4 encodings.
  // The integrator ties AWBURST to INCR outside this block.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // An AXI burst must never cross a 4 KB page.
  localparam int unsigned BOUNDARY_4K_BYTES = 4096;
  localparam int unsigned BOUNDARY_4K_BITS  = 12;

endpackage : uifdma_axi_wr_pkg
`default_nettype wire

// File: rtl/uifdma_burst_calc.sv
`default_nettype none
//============================================================================
// Module      : uifdma_burst_calc
// Description : Combinational burst-length calculator. Returns the smallest
//               of the three limits below:
//               - remaining beats in the transfer
//               - the configured maximum burst length
//               - the beats left before the next 4 KB page boundary
// Ports       :
//   addr_offset  in  12  low 12 bits of the burst start byte address
//   remaining    in  16  beats still to be written (must be non-zero)
//   burst_len    out  9  beats in the next burst, range 1..256
// Revision    : 1.0 - initial release
//============================================================================
module uifdma_burst_calc
  import uifdma_axi_wr_pkg::*;
#(
  parameter int AXI_DATA_WIDTH      = 128,
  parameter int M_AXI_MAX_BURST_LEN = 64
) (
  input  logic [BOUNDARY_4K_BITS-1:0] addr_offset,
  input  logic [15:0]                 remaining,
  output logic [8:0]                  burst_len
);

  localparam int          BEAT_SHIFT   = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [12:0] BEATS_PER_4K = 13'(BOUNDARY_4K_BYTES >> BEAT_SHIFT);

  logic [12:0] off_beats;
  logic [12:0] to_boundary;
  logic [16:0] rem_ext;
  logic [16:0] bnd_ext;
  logic [16:0] cap_ext;
  logic [16:0] min_rc;
  logic [16:0] min_all;

  always_comb begin
    // The start address is beat-aligned, so the shift drops no set bits.
    off_beats   = 13'(addr_offset >> BEAT_SHIFT);
    to_boundary = BEATS_PER_4K - off_beats;

    rem_ext = {1'b0, remaining};
    bnd_ext = 17'(to_boundary);
    cap_ext = 17'(M_AXI_MAX_BURST_LEN);

    min_rc  = (rem_ext < cap_ext) ? rem_ext : cap_ext;
    min_all = (min_rc < bnd_ext) ? min_rc : bnd_ext;

    // The maximum burst length is at most 256, so the result fits in 9 bits.
    burst_len = 9'(min_all);
  end

endmodule : uifdma_burst_calc
`default_nettype wire

// File: rtl/uifdma_axi_wr.sv
`default_nettype none
//============================================================================
// Module      : uifdma_axi_wr
// Description : FDMA write-request responder.
//               - Accepts a request: start address and length in beats.
//               - Pops beats from the controller's FWFT FIFO.
//               - Writes them to memory as a series of AXI4 INCR bursts.
//               - Keeps only one burst outstanding at a time.
//               - No burst crosses a 4 KB boundary.
// Ports       :
//   M_AXI_ACLK / M_AXI_ARESETN   clock, asynchronous active-low reset
//   fdma_waddr/wareq/wsize       request: start address, pulse, beat count
//   fdma_wbusy                   transfer in progress
//   fdma_wdata/wready            FWFT data and "beat available" from FIFO
//   fdma_wvalid                  FIFO read strobe (beat consumed)
//   fdma_werr                    sticky: non-OKAY write response seen
//   M_AXI_AW* / W* / B*          AXI4 write address, data, response
// Revision    : 1.0 - initial release
//============================================================================
module uifdma_axi_wr
  import uifdma_axi_wr_pkg::*;
#(
  parameter int AXI_DATA_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int M_AXI_MAX_BURST_LEN = 64
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,

  // Request interface
  input  logic [AXI_ADDR_WIDTH-1:0]     fdma_waddr,
  input  logic                          fdma_wareq,
  input  logic [15:0]                   fdma_wsize,
  output logic                          fdma_wbusy,

  // FIFO interface
  input  logic [AXI_DATA_WIDTH-1:0]     fdma_wdata,
  output logic                          fdma_wvalid,
  input  logic                          fdma_wready,

  // AXI write address channel
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,

  // AXI write data channel
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,

  // AXI write response channel
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,

  output logic                          fdma_werr
);

  localparam int BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  wr_state_e                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;   // current burst address
  logic [15:0]               rem_q,   rem_d;    // beats not yet acknowledged
  logic [7:0]                awlen_q, awlen_d;  // current burst length - 1
  logic [7:0]                beat_q,  beat_d;   // beats accepted in this burst
  logic                      werr_q,  werr_d;

  logic [8:0] calc_len;
  logic [8:0] cur_len;
  logic       start_req;
  logic       w_hs;
  logic       b_hs;
  logic       last_beat;

  assign cur_len   = {1'b0, awlen_q} + 9'd1;
  assign start_req = (state_q == ST_IDLE) && fdma_wareq && (fdma_wsize != 16'd0);
  assign w_hs      = (state_q == ST_W) && fdma_wready && M_AXI_WREADY;
  assign b_hs      = (state_q == ST_B) && M_AXI_BVALID;
  assign last_beat = (beat_q == awlen_q);

  // ------------------------------------------------------------------
  // Address / remaining-count update
  // ------------------------------------------------------------------
  // This block is kept separate from the FSM block. The burst
  // calculator reads addr_d/rem_d, and the FSM uses the calculator's
  // result to load the length of the next burst. Keeping the two
  // blocks apart avoids a false combinational loop.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (start_req) begin
      addr_d = fdma_waddr;
      rem_d  = fdma_wsize;
    end else if (b_hs) begin
      // The addition wraps naturally modulo 2^AXI_ADDR_WIDTH.
      addr_d = addr_q + (AXI_ADDR_WIDTH'(cur_len) << BEAT_SHIFT);
      rem_d  = rem_q - 16'(cur_len);
    end
  end

  uifdma_burst_calc #(
    .AXI_DATA_WIDTH      (AXI_DATA_WIDTH),
    .M_AXI_MAX_BURST_LEN (M_AXI_MAX_BURST_LEN)
  ) u_burst_calc (
    .addr_offset (addr_d[BOUNDARY_4K_BITS-1:0]),
    .remaining   (rem_d),
    .burst_len   (calc_len)
  );

  // ------------------------------------------------------------------
  // FSM next-state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    awlen_d = awlen_q;
    beat_d  = beat_q;
    werr_d  = werr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_AW;
          awlen_d = 8'(calc_len - 9'd1);
          werr_d  = 1'b0;
        end
      end

      ST_AW: begin
        if (M_AXI_AWREADY) begin
          state_d = ST_W;
          beat_d  = 8'd0;
        end
      end

      ST_W: begin
        if (w_hs) begin
          if (last_beat) begin
            state_d = ST_B;
            beat_d  = 8'd0;
          end else begin
            beat_d  = beat_q + 8'd1;
          end
        end
      end

      ST_B: begin
        if (b_hs) begin
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            werr_d = 1'b1;
          end
          if (rem_d != 16'd0) begin
            state_d = ST_AW;
            awlen_d = 8'(calc_len - 9'd1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      awlen_q <= '0;
      beat_q  <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      awlen_q <= awlen_d;
      beat_q  <= beat_d;
      werr_q  <= werr_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // All handshake outputs are decoded from the registered state.
  // Because of this, an asynchronous reset clears them at once.
  // WVALID only follows the FIFO's "beat available" flag, so a FIFO
  // stall holds the beat count and the data in place. The FIFO pop
  // happens in the same cycle as the accepted beat.
  assign fdma_wbusy    = (state_q != ST_IDLE);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWVALID = (state_q == ST_AW);
  assign M_AXI_WDATA   = fdma_wdata;
  assign M_AXI_WSTRB   = {(AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WVALID  = (state_q == ST_W) && fdma_wready;
  assign M_AXI_WLAST   = (state_q == ST_W) && last_beat;
  assign fdma_wvalid   = w_hs;
  assign M_AXI_BREADY  = (state_q == ST_B);
  assign fdma_werr     = werr_q;

endmodule : uifdma_axi_wr
`default_nettype wire

// File: tb/tb_uifdma_axi_wr.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_uifdma_axi_wr
// Description : Self-checking bench for uifdma_axi_wr.
//               - An AXI slave / FIFO model runs in its own process.
//               - A scoreboard holds the expected bursts and data beats.
//               - The directed sequence runs in the main initial block.
// Revision    : 1.0 - initial release
//============================================================================
module tb_uifdma_axi_wr;

  localparam int DW   = 128;
  localparam int AW   = 32;
  localparam int MAXB = 64;
  localparam int BPB  = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   fdma_waddr;
  logic            fdma_wareq;
  logic [15:0]     fdma_wsize;
  logic            fdma_wbusy;
  logic [DW-1:0]   fdma_wdata;
  logic            fdma_wvalid;
  logic            fdma_wready;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;
  logic            fdma_werr;

  always #5 clk = ~clk;

  uifdma_axi_wr #(
    .AXI_DATA_WIDTH      (DW),
    .AXI_ADDR_WIDTH      (AW),
    .M_AXI_MAX_BURST_LEN (MAXB)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .fdma_waddr    (fdma_waddr),
    .fdma_wareq    (fdma_wareq),
    .fdma_wsize    (fdma_wsize),
    .fdma_wbusy    (fdma_wbusy),
    .fdma_wdata    (fdma_wdata),
    .fdma_wvalid   (fdma_wvalid),
    .fdma_wready   (fdma_wready),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .fdma_werr     (fdma_werr)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;

  burst_t        exp_aw[$];
  logic [DW-1:0] exp_data[$];

  int          total = 0;
  int          bad   = 0;
  int unsigned push_ptr = 0;  // next beat index the scoreboard will expect
  int unsigned src_ptr  = 0;  // beat index currently shown by the FIFO
  bit          toggle_mode = 1'b0;
  bit          rand_w      = 1'b0;
  bit          rand_aw     = 1'b0;
  int          err_burst   = -1;
  int          burst_idx   = 0;
  bit          aw_acc      = 1'b0;
  int          cur_beat    = 0;
  logic [7:0]  cur_len     = 8'd0;
  bit          b_pending   = 1'b0;
  bit          b_take      = 1'b0;
  bit          b_check     = 1'b0;

  function automatic logic [DW-1:0] mk_data(int unsigned i);
    logic [31:0] v;
    v = i;
    return {v ^ 32'hDA7A_0000, ~v, v * 32'd3, v};
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference burst split: min(remaining, MAXB, beats to the 4 KB page end).
  task automatic push_req(logic [AW-1:0] a, logic [15:0] n);
    logic [AW-1:0] addr;
    int rem;
    int len;
    int bnd;
    addr = a;
    rem  = int'(n);
    while (rem > 0) begin
      bnd = (4096 - int'(addr[11:0])) / BPB;
      len = rem;
      if (len > MAXB) len = MAXB;
      if (len > bnd)  len = bnd;
      exp_aw.push_back({addr, 8'(len - 1)});
      addr = addr + AW'(len * BPB);
      rem  = rem - len;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_data.push_back(mk_data(push_ptr));
      push_ptr++;
    end
  endtask

  // ------------------------------------------------------------------
  // AXI slave + FIFO model + monitor
  // ------------------------------------------------------------------
  initial begin
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    fdma_wready   = 1'b0;
    fdma_wdata    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        M_AXI_BVALID = 1'b0;
        b_take       = 1'b0;
        b_pending    = 1'b0;
      end
      if (b_take) begin
        M_AXI_BVALID = 1'b0;
        b_take       = 1'b0;
      end
      if (b_pending) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
        b_pending    = 1'b0;
      end
      M_AXI_AWREADY = rand_aw ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_WREADY  = rand_w  ? 1'($urandom_range(0, 1)) : 1'b1;
      fdma_wready   = toggle_mode ? ~fdma_wready : 1'b1;
      fdma_wdata    = mk_data(src_ptr);
      #1;
      if (rst_n) begin
        if (b_check) begin
          b_check = 1'b0;
          if (exp_aw.size() == 0) chk("busy_after_b", fdma_wbusy, 0);
          else                    chk("awvalid_after_b", M_AXI_AWVALID, 1);
        end
        chk("fifo_pop", fdma_wvalid, M_AXI_WVALID & M_AXI_WREADY);
        chk("w_before_aw", M_AXI_WVALID & ~aw_acc, 0);
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          chk("aw_expected", exp_aw.size() != 0, 1);
          if (exp_aw.size() != 0) begin
            burst_t e;
            e = exp_aw.pop_front();
            chk("awaddr", M_AXI_AWADDR, e.addr);
            chk("awlen", M_AXI_AWLEN, e.len);
          end
          aw_acc   = 1'b1;
          cur_len  = M_AXI_AWLEN;
          cur_beat = 0;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          chk("w_expected", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) chk("wdata", M_AXI_WDATA, exp_data.pop_front());
          chk("wlast", M_AXI_WLAST, cur_beat == int'(cur_len));
          src_ptr++;
          if (cur_beat == int'(cur_len)) begin
            aw_acc    = 1'b0;
            b_pending = 1'b1;
          end
          cur_beat++;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          b_take  = 1'b1;
          b_check = 1'b1;
          burst_idx++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start(logic [AW-1:0] a, logic [15:0] n);
    @(negedge clk);
    push_req(a, n);
    burst_idx  = 0;
    fdma_waddr = a;
    fdma_wsize = n;
    fdma_wareq = 1'b1;
    @(negedge clk);
    fdma_wareq = 1'b0;
    #1;
    chk("busy_n1", fdma_wbusy, n != 16'd0);
    chk("awvalid_n1", M_AXI_AWVALID, n != 16'd0);
  endtask

  task automatic wait_idle(string tag);
    int cyc;
    cyc = 0;
    while ((fdma_wbusy || exp_aw.size() != 0 || exp_data.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk({tag, "_done"}, cyc < 5000, 1);
    chk({tag, "_drained"}, exp_aw.size() + exp_data.size(), 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"},    fdma_wbusy,    0);
    chk({tag, "_awvalid"}, M_AXI_AWVALID, 0);
    chk({tag, "_wvalid"},  M_AXI_WVALID,  0);
    chk({tag, "_wlast"},   M_AXI_WLAST,   0);
    chk({tag, "_bready"},  M_AXI_BREADY,  0);
    chk({tag, "_werr"},    fdma_werr,     0);
    chk({tag, "_pop"},     fdma_wvalid,   0);
    chk({tag, "_awaddr"},  M_AXI_AWADDR,  0);
    chk({tag, "_awlen"},   M_AXI_AWLEN,   0);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    fdma_wareq = 1'b0;
    fdma_waddr = '0;
    fdma_wsize = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk("wstrb", M_AXI_WSTRB, {(DW/8){1'b1}});
    @(negedge clk);
    rst_n = 1'b1;

    // A zero-length request is ignored.
    start(32'h0000_0100, 16'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("zero_size_busy", fdma_wbusy, 0);

    // Single beat.
    start(32'h0, 16'd1);
    chk("single_werr", fdma_werr, 0);
    wait_idle("single");

    // 256 beats: four bursts of 64.
    start(32'h0, 16'd256);
    wait_idle("four_bursts");

    // A transfer that crosses a 4 KB page.
    start(32'h0000_0F80, 16'd16);
    wait_idle("page_cross");

    // FIFO stalls and random AXI back-pressure.
    toggle_mode = 1'b1;
    rand_w      = 1'b1;
    rand_aw     = 1'b1;
    start(32'h0000_1230, 16'd100);
    wait_idle("stalls");
    toggle_mode = 1'b0;
    rand_w      = 1'b0;
    rand_aw     = 1'b0;

    // SLVERR on the 2nd of 3 bursts; the error is sticky to the end.
    err_burst = 1;
    start(32'h0000_2000, 16'd192);
    wait_idle("slverr");
    chk("werr_sticky", fdma_werr, 1);
    err_burst = -1;

    // The next request clears the error.
    // A request made while busy is ignored.
    start(32'h0000_3000, 16'd40);
    chk("werr_cleared", fdma_werr, 0);
    repeat (5) @(negedge clk);
    fdma_waddr = 32'h0000_5000;
    fdma_wsize = 16'd4;
    fdma_wareq = 1'b1;
    @(negedge clk);
    fdma_wareq = 1'b0;
    wait_idle("busy_ignore");

    // Address wrap at the top of the address space.
    start(32'hFFFF_FFC0, 16'd8);
    wait_idle("wrap");

    // Reset in the middle of the data phase.
    start(32'h0000_4000, 16'd64);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_aw.delete();
    exp_data.delete();
    aw_acc    = 1'b0;
    b_pending = 1'b0;
    b_check   = 1'b0;
    repeat (2) @(negedge clk);
    push_ptr = src_ptr;
    rst_n    = 1'b1;
    start(32'h0000_6000, 16'd20);
    wait_idle("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uifdma_axi_wr
`default_nettype wire
